xmuxn_seq: RTL and testbench
============================

Name: xmuxn_seq

Overview:
- Parametrised successor of the Versat 4:1 registered mux functional unit.
- N_IN-input registered selector with:
  - a programmable start delay;
  - a programmable active-cycle count (iterations);
  - a configurable output pipeline depth;
  - a per-sample valid flag.
- Sits in the Versat datapath alongside other run/done functional units. The controller pulses run; done reports completion.

Parameters:
- DATA_W, 32, data width of each input and of the output.
- N_IN, 8, number of selectable inputs (2..32).
- SEL_W, $clog2(N_IN), select width; derived, never overridden.
- DELAY_W, 8, start-delay configuration width.
- ITER_W, 16, iteration-count configuration width.
- PIPE, 1, output register stages (1..4).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  start pulse; sampled only in IDLE
- done  out  1  1 = idle/complete, 0 = busy
- in_flat  in  N_IN*DATA_W  packed inputs; input k occupies [k*DATA_W +: DATA_W]
- sel  in  SEL_W  input select; latched on accepted run
- delay  in  DELAY_W  cycles between run and first capture; latched on accepted run
- iter  in  ITER_W  number of samples to capture; latched on accepted run
- out0  out  DATA_W  selected data, last pipeline stage
- out_valid  out  1  out0 holds a sample of the current run

Behaviour:
- Reset (async, any state, including mid-run):
  - state = IDLE; all counters and pipeline stages = 0.
  - out0 = 0, out_valid = 0, done = 1.
- States: IDLE, WAIT, ACTIVE, DRAIN.
- IDLE:
  - done = 1.
  - run = 1 and iter != 0: latch sel_q/delay_q/iter_q, done = 0. Call this edge E0.
    - Go to WAIT with dcnt = delay if delay != 0.
    - Go to ACTIVE with icnt = iter if delay == 0.
  - run = 1 and iter == 0: no-op. Stays IDLE, done stays 1, no valid.
- WAIT:
  - dcnt decrements each edge.
  - When dcnt reaches 1 (transition edge), go to ACTIVE with icnt = iter_q.
  - run is ignored.
- ACTIVE:
  - Each edge captures in_flat[sel_q] into pipeline stage 1 with valid = 1, and decrements icnt.
  - On the edge capturing the last sample (icnt == 1), go to DRAIN.
  - run is ignored.
- Capture timing: samples are captured on edges E0+D+1 … E0+D+iter (D = latched delay).
- Out-of-range select: sel_q >= N_IN captures 0 (valid still 1).
- Pipeline: out0/out_valid equal stage PIPE. A sample captured at edge t appears on out0 after edge t+PIPE-1.
- Outside ACTIVE, stage-1 valid = 0 and stage-1 data holds its previous value. out0 therefore holds the last sample after the run; it is never cleared except by rst.
- DRAIN:
  - Waits until the pipeline has no valid, then returns to IDLE.
  - done rises on edge E0+D+iter+PIPE, the same edge out_valid falls.
  - out_valid is high for exactly iter consecutive cycles.
- Back-to-back: run may be accepted on the cycle done = 1 is first visible. There is no dead cycle beyond the IDLE state.
- Live inputs: in_flat is not latched; each capture uses the current input value.
- Counter rules:
  - Counters are unsigned.
  - delay = 2^DELAY_W-1 and iter = 2^ITER_W-1 must work with no wrap-around or overflow.

Decomposition:
- Package xmuxn_pkg:
  - state encoding localparams (IDLE = 2'd0, WAIT = 2'd1, ACTIVE = 2'd2, DRAIN = 2'd3);
  - PIPE bounds (PIPE_MIN = 1, PIPE_MAX = 4).
- Sub-module xpipe_dv:
  - PIPE-stage data+valid shift register with async reset to zero;
  - reusable by other Versat units.
- Top holds the FSM, counters, config latches and the mux.

Test Plan:
1. Reset mid-ACTIVE (N_IN=8, iter=10, rst asserted at 5th valid) -> out0=0, out_valid=0, done=1 immediately (async); later run restarts normally.
2. N_IN=8, PIPE=1, sel=5, in5=0xA5A5_0001 incrementing by 1 per cycle, delay=0, iter=4, run at E0 -> out_valid high at edges E0+1..E0+4; out0 = in5 value at each capture; done rises at edge E0+5; out0 holds the 4th sample.
3. delay=3, iter=2, PIPE=3, sel=0, in0=0x11 -> first valid after edge E0+6; valid for 2 cycles; done rises at edge E0+8.
4. iter=0, run=1 -> done stays 1, out_valid never asserts, out0 unchanged. Separately: sel=7 with N_IN=6 -> valid samples equal 0.
5. run pulsed during WAIT and ACTIVE with different sel/iter -> ignored; the original run's timing and data are unchanged. A run on the first done=1 cycle starts a new run with no gap.

Source files
------------

// File: rtl/xmuxn_pkg.sv
// xmuxn_pkg: shared types and constants for the xmuxn_seq selector unit.
//   xmux_state_t  : FSM state encoding (IDLE, WAIT, ACTIVE, DRAIN)
//   PIPE_MIN/MAX  : legal range of output pipeline depth
package xmuxn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } xmux_state_t;

  localparam int PIPE_MIN = 1;
  localparam int PIPE_MAX = 4;

endpackage

// File: rtl/xpipe_dv.sv
// xpipe_dv: DEPTH-stage data+valid shift register, asynchronous reset to zero.
//   clk, rst       : clock, asynchronous active-high reset
//   valid_i/data_i : stage-1 input; data loads only when valid_i is high,
//                    otherwise stage 1 keeps its previous data
//   data_o/valid_o : last stage
//   stage_valid_o  : valid bit of every stage (bit 0 = stage 1)
module xpipe_dv #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [DEPTH-1:0]  stage_valid_o
);

  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      // Stage 1 holds its data between samples so the output keeps the
      // last sample once a burst has drained.
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign data_o        = data_q[DEPTH-1];
  assign valid_o       = valid_q[DEPTH-1];
  assign stage_valid_o = valid_q;

endmodule

// File: rtl/xmuxn_seq.sv
// xmuxn_seq: N_IN-input registered selector with start delay, iteration
// count and PIPE-deep output pipeline.
//   clk, rst  : clock, asynchronous active-high reset
//   run       : start pulse, accepted only in IDLE with iter != 0
//   done      : 1 when idle / complete
//   in_flat   : packed inputs, input k at [k*DATA_W +: DATA_W] (not latched)
//   sel/delay/iter : configuration, latched when run is accepted
//   out0      : selected data from the last pipeline stage
//   out_valid : out0 holds a sample of the current run
module xmuxn_seq
  import xmuxn_pkg::*;
#(
  parameter int  DATA_W  = 32,
  parameter int  N_IN    = 8,
  parameter int  DELAY_W = 8,
  parameter int  ITER_W  = 16,
  parameter int  PIPE    = 1,
  localparam int SEL_W   = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic                   done,
  input  logic [N_IN*DATA_W-1:0] in_flat,
  input  logic [SEL_W-1:0]       sel,
  input  logic [DELAY_W-1:0]     delay,
  input  logic [ITER_W-1:0]      iter,
  output logic [DATA_W-1:0]      out0,
  output logic                   out_valid
);

  localparam int N_SLOT = 1 << SEL_W;
  // Stages that still feed the last stage; the last stage itself drains
  // on the same edge that returns the FSM to IDLE.
  localparam logic [PIPE-1:0] FWD_MASK = {PIPE{1'b1}} >> 1;

  xmux_state_t        state_q, state_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic [ITER_W-1:0]  icnt_q, icnt_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               cap;
  logic [PIPE-1:0]    stage_valid;
  logic [DATA_W-1:0]  mux_data;
  logic               inflight;

  // Unpack inputs; select codes at or above N_IN read as zero.
  logic [DATA_W-1:0] in_arr [N_SLOT];
  for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_unpack
    if (gi < N_IN) begin : g_live
      assign in_arr[gi] = in_flat[gi*DATA_W +: DATA_W];
    end else begin : g_zero
      assign in_arr[gi] = '0;
    end
  end
  assign mux_data = in_arr[sel_q];

  assign inflight = |(stage_valid & FWD_MASK);
  assign done     = (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      icnt_q  <= '0;
      iter_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      icnt_q  <= icnt_d;
      iter_q  <= iter_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    icnt_d  = icnt_q;
    iter_d  = iter_q;
    sel_d   = sel_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (run && (iter != '0)) begin
          sel_d  = sel;
          iter_d = iter;
          if (delay != '0) begin
            state_d = WAIT;
            dcnt_d  = delay;
          end else begin
            state_d = ACTIVE;
            icnt_d  = iter;
          end
        end
      end
      WAIT: begin
        dcnt_d = dcnt_q - DELAY_W'(1);
        if (dcnt_q == DELAY_W'(1)) begin
          state_d = ACTIVE;
          icnt_d  = iter_q;
        end
      end
      ACTIVE: begin
        cap    = 1'b1;
        icnt_d = icnt_q - ITER_W'(1);
        if (icnt_q == ITER_W'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  xpipe_dv #(
    .DATA_W(DATA_W),
    .DEPTH (PIPE)
  ) u_pipe (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (cap),
    .data_i       (mux_data),
    .data_o       (out0),
    .valid_o      (out_valid),
    .stage_valid_o(stage_valid)
  );

endmodule

// File: tb/tb_xmuxn_seq.sv
// tb_xmuxn_seq: two instances (N_IN=8/PIPE=1 and N_IN=6/PIPE=3) sharing
// control inputs, checked every cycle against a timeline model.
module tb_xmuxn_seq;

  localparam int HN = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic [2:0]   sel = '0;
  logic [7:0]   delay = '0;
  logic [9:0]   iter = '0;
  logic [255:0] in_flat = '0;

  logic [31:0] out0_a, out0_b;
  logic        ov_a, ov_b, done_a, done_b;

  logic [31:0] dout [2];
  logic        dval [2];
  logic        ddone [2];
  assign dout[0] = out0_a;  assign dval[0] = ov_a;  assign ddone[0] = done_a;
  assign dout[1] = out0_b;  assign dval[1] = ov_b;  assign ddone[1] = done_b;

  xmuxn_seq #(.DATA_W(32), .N_IN(8), .DELAY_W(8), .ITER_W(10), .PIPE(1)) u_a (
    .clk(clk), .rst(rst), .run(run), .done(done_a), .in_flat(in_flat),
    .sel(sel), .delay(delay), .iter(iter), .out0(out0_a), .out_valid(ov_a));

  xmuxn_seq #(.DATA_W(32), .N_IN(6), .DELAY_W(8), .ITER_W(10), .PIPE(3)) u_b (
    .clk(clk), .rst(rst), .run(run), .done(done_b), .in_flat(in_flat[191:0]),
    .sel(sel), .delay(delay), .iter(iter), .out0(out0_b), .out_valid(ov_b));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Timeline model: a run accepted at edge E0 captures on edges
  // E0+D+1..E0+D+iter, a capture at edge t shows on out0 after edge
  // t+P-1, and done is low after edges E0..E0+D+iter+P-1.
  int          m_cyc = 0;
  int          m_n [2] = '{8, 6};
  int          m_p [2] = '{1, 3};
  int          m_end [2], e_lo [2], e_hi [2], rst_edge [2], m_sel [2];
  logic [31:0] hist_d [2][HN];
  logic        hist_v [2][HN];
  int          f_lane = -1;
  logic [31:0] f_val = '0;
  logic [31:0] f_step = '0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      rst_edge[d] = m_cyc;  m_end[d] = m_cyc;
      e_lo[d] = 1;  e_hi[d] = 0;
      hist_d[d][m_cyc % HN] = '0;  hist_v[d][m_cyc % HN] = 1'b0;
    end
  endtask

  task automatic tick();
    int c;
    logic [31:0] cd;
    logic cv;
    c = m_cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        rst_edge[d] = c;  m_end[d] = c;  e_lo[d] = 1;  e_hi[d] = 0;
        hist_d[d][c % HN] = '0;  hist_v[d][c % HN] = 1'b0;
      end else begin
        if (c - 1 >= m_end[d] && run && iter != '0) begin
          m_sel[d] = int'(sel);
          e_lo[d]  = c + int'(delay) + 1;
          e_hi[d]  = c + int'(delay) + int'(iter);
          m_end[d] = e_hi[d] + m_p[d];
        end
        cd = hist_d[d][(c - 1) % HN];
        cv = 1'b0;
        if (c >= e_lo[d] && c <= e_hi[d]) begin
          cv = 1'b1;
          cd = (m_sel[d] < m_n[d]) ? in_flat[m_sel[d]*32 +: 32] : 32'd0;
        end
        hist_d[d][c % HN] = cd;
        hist_v[d][c % HN] = cv;
      end
    end
    @(posedge clk);
    #1;
    m_cyc = c;
    for (int k = 0; k < 8; k++) in_flat[k*32 +: 32] = $urandom();
    if (f_lane >= 0) begin
      f_val = f_val + f_step;
      in_flat[f_lane*32 +: 32] = f_val;
    end
  endtask

  function automatic void get_exp(input int d, output logic [31:0] eo,
                                  output logic ev, output logic edn);
    int s;
    s = m_cyc - m_p[d] + 1;
    if (s <= rst_edge[d]) begin
      eo = '0;  ev = 1'b0;
    end else begin
      eo = hist_d[d][s % HN];  ev = hist_v[d][s % HN];
    end
    edn = (m_cyc >= m_end[d]);
  endfunction

  task automatic test_reset();
    for (int d = 0; d < 2; d++) model_reset();
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (dout[d] !== 32'd0 || dval[d] !== 1'b0 || ddone[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset dut%0d: out0=%h valid=%b done=%b, want 0 0 1", d, dout[d], dval[d], ddone[d]);
      end
    end
    rst = 1'b0;
    $display("[TB] reset checked at cycle %0d", m_cyc);
  endtask

  task automatic test_reset_mid_active();
    logic [31:0] e_o;
    logic e_v, e_dn;
    int nv;
    bit found;
    nv = 0;  found = 0;
    sel = 3'($urandom_range(0, 5));  delay = 8'd0;  iter = 10'd10;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      for (int d = 0; d < 2; d++) begin
        get_exp(d, e_o, e_v, e_dn);
        n_tests++;
        if (dout[d] !== e_o || dval[d] !== e_v || ddone[d] !== e_dn) begin
          n_fail++;
          $display("FAIL mid_reset_run dut%0d cyc%0d: out0=%h valid=%b done=%b, want %h %b %b", d, m_cyc, dout[d], dval[d], ddone[d], e_o, e_v, e_dn);
        end
      end
      if (dval[0]) nv++;
      if (nv == 5) found = 1;
      else tick();
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL mid_reset_wait: saw %0d valid cycles, want 5 within budget", nv);
    end
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (dout[d] !== 32'd0 || dval[d] !== 1'b0 || ddone[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_reset_async dut%0d: out0=%h valid=%b done=%b, want 0 0 1", d, dout[d], dval[d], ddone[d]);
      end
    end
    tick();
    tick();
    rst = 1'b0;
    sel = 3'd1;  delay = 8'd2;  iter = 10'd3;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 0; k < 12; k++) begin
      for (int d = 0; d < 2; d++) begin
        get_exp(d, e_o, e_v, e_dn);
        n_tests++;
        if (dout[d] !== e_o || dval[d] !== e_v || ddone[d] !== e_dn) begin
          n_fail++;
          $display("FAIL restart dut%0d cyc%0d: out0=%h valid=%b done=%b, want %h %b %b", d, m_cyc, dout[d], dval[d], ddone[d], e_o, e_v, e_dn);
        end
      end
      tick();
    end
    $display("[TB] reset mid-active and restart done at cycle %0d", m_cyc);
  endtask

  task automatic test_basic();
    logic [31:0] e_o;
    logic e_v, e_dn;
    f_lane = 5;  f_val = 32'hA5A5_0000;  f_step = 32'd1;
    in_flat[5*32 +: 32] = f_val;
    sel = 3'd5;  delay = 8'd0;  iter = 10'd4;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        get_exp(d, e_o, e_v, e_dn);
        n_tests++;
        if (dout[d] !== e_o || dval[d] !== e_v || ddone[d] !== e_dn) begin
          n_fail++;
          $display("FAIL basic dut%0d cyc%0d: out0=%h valid=%b done=%b, want %h %b %b", d, m_cyc, dout[d], dval[d], ddone[d], e_o, e_v, e_dn);
        end
      end
    end
    n_tests++;
    if (dout[0] !== 32'hA5A5_0004) begin
      n_fail++;
      $display("FAIL basic_hold: out0=%h, want a5a50004", dout[0]);
    end
    f_lane = -1;
    $display("[TB] basic sel=5 iter=4 checked at cycle %0d", m_cyc);
  endtask

  task automatic test_delay_pipe();
    logic [31:0] e_o;
    logic e_v, e_dn;
    int first_v, done_k;
    first_v = -1;  done_k = -1;
    f_lane = 0;  f_val = 32'h11;  f_step = 32'd0;
    in_flat[31:0] = f_val;
    sel = 3'd0;  delay = 8'd3;  iter = 10'd2;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        get_exp(d, e_o, e_v, e_dn);
        n_tests++;
        if (dout[d] !== e_o || dval[d] !== e_v || ddone[d] !== e_dn) begin
          n_fail++;
          $display("FAIL delay_pipe dut%0d cyc%0d: out0=%h valid=%b done=%b, want %h %b %b", d, m_cyc, dout[d], dval[d], ddone[d], e_o, e_v, e_dn);
        end
      end
      if (dval[1] === 1'b1 && first_v < 0) first_v = k;
      if (ddone[1] === 1'b1 && done_k < 0) done_k = k;
    end
    n_tests++;
    if (first_v != 6 || done_k != 8) begin
      n_fail++;
      $display("FAIL delay_pipe_timing: first valid E0+%0d done E0+%0d, want E0+6 and E0+8", first_v, done_k);
    end
    f_lane = -1;
    $display("[TB] delay=3 iter=2 PIPE=3 checked at cycle %0d", m_cyc);
  endtask

  task automatic test_iter_zero_and_oob();
    logic [31:0] e_o;
    logic e_v, e_dn;
    logic [31:0] held;
    held = dout[0];
    sel = 3'd3;  delay = 8'd0;  iter = 10'd0;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (ddone[0] !== 1'b1 || dval[0] !== 1'b0 || dout[0] !== held) begin
        n_fail++;
        $display("FAIL iter_zero cyc%0d: out0=%h valid=%b done=%b, want %h 0 1", m_cyc, dout[0], dval[0], ddone[0], held);
      end
      tick();
    end
    sel = 3'd7;  delay = 8'd1;  iter = 10'd5;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 0; k < 12; k++) begin
      for (int d = 0; d < 2; d++) begin
        get_exp(d, e_o, e_v, e_dn);
        n_tests++;
        if (dout[d] !== e_o || dval[d] !== e_v || ddone[d] !== e_dn) begin
          n_fail++;
          $display("FAIL oob_sel dut%0d cyc%0d: out0=%h valid=%b done=%b, want %h %b %b", d, m_cyc, dout[d], dval[d], ddone[d], e_o, e_v, e_dn);
        end
      end
      if (dval[1] === 1'b1) begin
        n_tests++;
        if (dout[1] !== 32'd0) begin
          n_fail++;
          $display("FAIL oob_zero cyc%0d: out0=%h, want 0", m_cyc, dout[1]);
        end
      end
      tick();
    end
    $display("[TB] iter=0 and out-of-range select checked at cycle %0d", m_cyc);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e_o;
    logic e_v, e_dn;
    bit seen;
    seen = 0;
    sel = 3'd2;  delay = 8'd4;  iter = 10'd6;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      for (int d = 0; d < 2; d++) begin
        get_exp(d, e_o, e_v, e_dn);
        n_tests++;
        if (dout[d] !== e_o || dval[d] !== e_v || ddone[d] !== e_dn) begin
          n_fail++;
          $display("FAIL b2b dut%0d cyc%0d: out0=%h valid=%b done=%b, want %h %b %b", d, m_cyc, dout[d], dval[d], ddone[d], e_o, e_v, e_dn);
        end
      end
      if (ddone[0] === 1'b1) begin
        seen = 1;
      end else begin
        // Disturbing runs with a different config while busy.
        run = 1'($urandom_range(0, 1));
        sel = 3'($urandom_range(0, 7));
        iter = 10'($urandom_range(1, 20));
        delay = 8'($urandom_range(0, 3));
        tick();
        run = 1'b0;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL b2b_wait: done never rose within budget");
    end
    sel = 3'd4;  delay = 8'd0;  iter = 10'd3;
    run = 1'b1;
    tick();
    run = 1'b0;
    n_tests++;
    if (ddone[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: done=%b after run on first done cycle, want 0", ddone[0]);
    end
    for (int k = 0; k < 12; k++) begin
      for (int d = 0; d < 2; d++) begin
        get_exp(d, e_o, e_v, e_dn);
        n_tests++;
        if (dout[d] !== e_o || dval[d] !== e_v || ddone[d] !== e_dn) begin
          n_fail++;
          $display("FAIL b2b_second dut%0d cyc%0d: out0=%h valid=%b done=%b, want %h %b %b", d, m_cyc, dout[d], dval[d], ddone[d], e_o, e_v, e_dn);
        end
      end
      tick();
    end
    $display("[TB] ignored runs and back-to-back checked at cycle %0d", m_cyc);
  endtask

  task automatic test_random();
    logic [31:0] e_o;
    logic e_v, e_dn;
    for (int k = 0; k < 300; k++) begin
      run   = ($urandom_range(0, 2) == 0);
      sel   = 3'($urandom_range(0, 7));
      delay = 8'($urandom_range(0, 5));
      iter  = 10'($urandom_range(0, 8));
      tick();
      run = 1'b0;
      for (int d = 0; d < 2; d++) begin
        get_exp(d, e_o, e_v, e_dn);
        n_tests++;
        if (dout[d] !== e_o || dval[d] !== e_v || ddone[d] !== e_dn) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: out0=%h valid=%b done=%b, want %h %b %b", d, m_cyc, dout[d], dval[d], ddone[d], e_o, e_v, e_dn);
        end
      end
    end
    $display("[TB] random traffic checked at cycle %0d", m_cyc);
  endtask

  task automatic test_max_counts();
    logic [31:0] e_o;
    logic e_v, e_dn;
    int nv;
    nv = 0;
    for (int k = 0; k < 10; k++) tick();
    sel = 3'd1;  delay = 8'd255;  iter = 10'd1023;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 0; k < 1300; k++) begin
      tick();
      if (dval[0] === 1'b1) nv++;
      for (int d = 0; d < 2; d++) begin
        get_exp(d, e_o, e_v, e_dn);
        n_tests++;
        if (dout[d] !== e_o || dval[d] !== e_v || ddone[d] !== e_dn) begin
          n_fail++;
          $display("FAIL max_counts dut%0d cyc%0d: out0=%h valid=%b done=%b, want %h %b %b", d, m_cyc, dout[d], dval[d], ddone[d], e_o, e_v, e_dn);
        end
      end
    end
    n_tests++;
    if (nv != 1023) begin
      n_fail++;
      $display("FAIL max_valid_count: %0d valid cycles, want 1023", nv);
    end
    $display("[TB] delay=255 iter=1023 checked at cycle %0d", m_cyc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay_pipe();
    test_reset_mid_active();
    test_iter_zero_and_oob();
    test_back_to_back();
    test_random();
    test_max_counts();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
